// File: rtl/filter_capture_pkg.sv
// Shared types and defaults for the triggered filter capture buffer.
package filter_capture_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/filter_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array has no reset; the read register only updates when re is high.
module capture_ram
  import filter_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port; holds the last read word while re is low.
  always_ff @(posedge sys_clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/filter_capture.sv
// Triggered capture buffer on the filter output stream.
// Arm, wait for a rising threshold crossing (or a forced trigger), store DEPTH
// consecutive samples, then play them back over a valid/ready stream.
//
// Readout stream: a sample transfers on a cycle where rd_valid && rd_ready are
// both high at the rising edge. While rd_valid is high and rd_ready low, rd_data,
// rd_last and rd_valid stay unchanged. rd_valid never depends on rd_ready.
//
// Readout pipeline: RAM read register (q_vld) -> skid register -> output register.
// A read is issued only if the word it returns is guaranteed a free slot, which
// keeps one sample per cycle under continuous ready and loses nothing on stalls.
// Index 0 is prefetched during the final CAPTURE cycle so rd_valid rises one
// cycle after READOUT is entered.
module filter_capture
  import filter_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] i,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] threshold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] prev;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              issue_done;
  logic              q_vld;
  logic              q_last;
  logic [DATA_W-1:0] sk_data;
  logic              sk_valid;
  logic              sk_last;

  logic              trig;
  logic              hs;
  logic [1:0]        occ;
  logic              can_issue;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (i),
    .re      (ram_re),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

  // Trigger compare, handshake, read-issue credit and RAM port control.
  always_comb begin
    trig      = ($signed(prev) < $signed(threshold)) && ($signed(i) >= $signed(threshold));
    hs        = rd_valid && rd_ready;
    occ       = 2'(rd_valid) + 2'(sk_valid) + 2'(q_vld);
    can_issue = (occ - 2'(hs)) <= 2'd1;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    if (!sys_rst && !abort) begin
      case (state)
        ARMED: begin
          if (trig || force_trig) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
          end
        end
        CAPTURE: begin
          ram_we = 1'b1;
          if (wr_ptr == LAST_ADDR) begin
            ram_re    = 1'b1;
            ram_raddr = '0;
          end
        end
        READOUT: begin
          if (!issue_done && can_issue) ram_re = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Previous-sample register for edge detection; runs in every state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) prev <= '0;
    else         prev <= i;
  end

  // Capture sequencer, pointers and readout skid pipeline.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      issue_done <= 1'b0;
      q_vld      <= 1'b0;
      q_last     <= 1'b0;
      sk_valid   <= 1'b0;
      sk_last    <= 1'b0;
      sk_data    <= '0;
    end else if (abort) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      issue_done <= 1'b0;
      q_vld      <= 1'b0;
      q_last     <= 1'b0;
      sk_valid   <= 1'b0;
      sk_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= ARMED;
            busy   <= 1'b1;
            wr_ptr <= '0;
          end
        end
        ARMED: begin
          if (trig || force_trig) begin
            state  <= CAPTURE;
            wr_ptr <= ADDR_W'(1);
          end
        end
        CAPTURE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_ADDR) begin
            state      <= READOUT;
            rd_ptr     <= ADDR_W'(1);
            issue_done <= 1'b0;
            q_vld      <= 1'b1;
            q_last     <= 1'b0;
          end
        end
        READOUT: begin
          if (ram_re) begin
            q_vld  <= 1'b1;
            q_last <= (rd_ptr == LAST_ADDR);
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_ADDR) issue_done <= 1'b1;
          end else begin
            q_vld <= 1'b0;
          end
          if (hs) begin
            if (rd_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else if (sk_valid) begin
              rd_data  <= sk_data;
              rd_last  <= sk_last;
              rd_valid <= 1'b1;
              sk_valid <= q_vld;
              sk_data  <= ram_rdata;
              sk_last  <= q_last;
            end else if (q_vld) begin
              rd_data  <= ram_rdata;
              rd_last  <= q_last;
              rd_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
            end
          end else if (q_vld) begin
            if (!rd_valid) begin
              rd_data  <= ram_rdata;
              rd_last  <= q_last;
              rd_valid <= 1'b1;
            end else begin
              sk_data  <= ram_rdata;
              sk_last  <= q_last;
              sk_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_capture.sv
// Bench for filter_capture: randomized records checked against a sample-level
// reference model feeding an expected queue, with a separate readout monitor.
module tb_filter_capture;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [DATA_W-1:0] i;
  logic              arm;
  logic              abort;
  logic              force_trig;
  logic [DATA_W-1:0] threshold;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  filter_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i          (i),
    .arm        (arm),
    .abort      (abort),
    .force_trig (force_trig),
    .threshold  (threshold),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- drivers ----------------
  int i_mode;     // 0 ramp, 1 random, 2 constant
  logic signed [DATA_W-1:0] ramp_v;
  logic [DATA_W-1:0] i_const;
  int rdy_mode;   // 0 high, 1 toggle, 2 low, 3 random

  task automatic drive_i();
    case (i_mode)
      0: begin i = ramp_v; ramp_v = ramp_v + 16'sd1; end
      1: i = DATA_W'($urandom_range(0, 65535));
      default: i = i_const;
    endcase
  endtask

  task automatic drive_rdy();
    case (rdy_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = ~rd_ready;
      2: rd_ready = 1'b0;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    drive_i();
    drive_rdy();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1; tick(); force_trig = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!rd_valid && n < max_cyc) begin tick(); n++; end
    check(name, rd_valid, 1'b1);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin tick(); n++; end
    check({name, "_done"}, done, 1'b1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- reference model ----------------
  // A record is the DEPTH samples starting at the first qualifying sample
  // seen while armed; it is pushed to exp_q as the samples arrive.
  typedef enum int {M_IDLE, M_ARMED, M_CAP, M_READ} mphase_t;
  mphase_t m_phase = M_IDLE;
  logic [DATA_W-1:0] prev_m = '0;
  int cap_n = 0;
  int rd_left = 0;

  always @(negedge sys_clk) begin
    logic trig_m;
    check("busy", busy, m_phase != M_IDLE);
    trig_m = ($signed(prev_m) < $signed(threshold)) && ($signed(i) >= $signed(threshold));
    if (sys_rst || abort) begin
      m_phase = M_IDLE;
      exp_q.delete();
    end else begin
      case (m_phase)
        M_IDLE:  if (arm) m_phase = M_ARMED;
        M_ARMED: if (trig_m || force_trig) begin
          exp_q.push_back(i);
          cap_n = 1;
          m_phase = M_CAP;
        end
        M_CAP: begin
          exp_q.push_back(i);
          cap_n++;
          if (cap_n == DEPTH) begin m_phase = M_READ; rd_left = DEPTH; end
        end
        default: if (rd_valid && rd_ready) begin
          rd_left--;
          if (rd_left == 0) m_phase = M_IDLE;
        end
      endcase
    end
    prev_m = sys_rst ? '0 : i;
  end

  // ---------------- readout monitor / scoreboard ----------------
  logic done_exp = 1'b0;
  logic stall_p = 1'b0;
  logic [DATA_W-1:0] stall_d;
  logic stall_l;

  always @(negedge sys_clk) begin
    logic [DATA_W-1:0] exp_d;
    logic exp_last;
    check("done", done, done_exp);
    done_exp = 1'b0;
    if (stall_p) begin
      check("stall_valid", rd_valid, 1'b1);
      check("stall_data", rd_data, stall_d);
      check("stall_last", rd_last, stall_l);
    end
    stall_p = rd_valid && !rd_ready && !abort && !sys_rst;
    stall_d = rd_data;
    stall_l = rd_last;
    if (rd_valid && rd_ready && !abort && !sys_rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got %0h with no sample expected (t=%0t)", rd_data, $time);
      end else begin
        exp_last = (exp_q.size() == 1);
        exp_d = exp_q.pop_front();
        check("rd_data", rd_data, exp_d);
        check("rd_last", rd_last, exp_last);
        if (exp_last) done_exp = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    sys_rst = 1'b1; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    threshold = 16'h7fff; i = '0; rd_ready = 1'b0;
    i_mode = 2; i_const = '0; ramp_v = '0; rdy_mode = 0;
    ticks(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_last", rd_last, 1'b0);
    check("rst_data", rd_data, '0);
    sys_rst = 1'b0;
    ticks(2);

    // Forced trigger on a ramp; check latency and sustained rate.
    i_mode = 0; ramp_v = -16'sd1; drive_i();
    arm = 1'b1; tick(); arm = 1'b0;
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    n = 1;
    while (!rd_valid && n < 2000) begin tick(); n++; end
    check("force_valid_latency", n, DEPTH + 1);
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    check("force_done_latency", n, DEPTH);
    check("force_drained", exp_q.size(), 0);
    ticks(3);

    // Threshold crossing: held above threshold before arm, then ramp from -50.
    threshold = 16'd100; i_mode = 2; i_const = 16'd150; drive_i();
    ticks(5);
    check("thr_no_early_trig", busy, 1'b0);
    i_mode = 0; ramp_v = -16'sd50; drive_i();
    pulse_arm();
    wait_done("thr", 2000);
    ticks(3);

    // Backpressure: toggling ready, then a long stall.
    threshold = 16'h7fff; i_mode = 1; rdy_mode = 1;
    pulse_arm(); pulse_force();
    wait_valid("bp_valid", 1000);
    ticks(40);
    rdy_mode = 2; ticks(20);
    rdy_mode = 0;
    wait_done("bp", 2000);
    ticks(3);

    // Abort mid-capture, then a fresh record with random ready.
    pulse_arm(); pulse_force();
    ticks(100);
    pulse_abort();
    check("abort_cap_valid", rd_valid, 1'b0);
    check("abort_cap_busy", busy, 1'b0);
    rdy_mode = 3;
    pulse_arm(); pulse_force();
    wait_done("after_abort_cap", 3000);
    ticks(3);

    // Abort mid-readout, then a fresh record.
    pulse_arm(); pulse_force();
    wait_valid("abort_rd_valid_wait", 1000);
    ticks(50);
    pulse_abort();
    check("abort_rd_valid", rd_valid, 1'b0);
    check("abort_rd_busy", busy, 1'b0);
    check("abort_rd_done", done, 1'b0);
    pulse_arm(); pulse_force();
    wait_done("after_abort_rd", 3000);
    ticks(3);

    // arm + force together in IDLE: armed but no capture; arm during readout ignored.
    threshold = 16'd100; i_mode = 2; i_const = '0; drive_i();
    arm = 1'b1; force_trig = 1'b1; tick(); arm = 1'b0; force_trig = 1'b0;
    ticks(10);
    check("armforce_busy", busy, 1'b1);
    check("armforce_no_valid", rd_valid, 1'b0);
    i_mode = 1; rdy_mode = 3;
    pulse_force();
    wait_valid("armrd_valid", 1000);
    for (int k = 0; k < 5; k++) begin pulse_arm(); ticks(7); end
    wait_done("arm_in_readout", 3000);
    ticks(3);

    // Reset mid-readout, then re-arm with a crossing at threshold 0.
    threshold = 16'h7fff; rdy_mode = 0;
    pulse_arm(); pulse_force();
    wait_valid("rst_rd_valid_wait", 1000);
    ticks(30);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_valid", rd_valid, 1'b0);
    check("midrst_last", rd_last, 1'b0);
    check("midrst_data", rd_data, '0);
    threshold = '0; i_mode = 2; i_const = 16'hffff; drive_i();
    pulse_arm();
    i_mode = 0; ramp_v = 16'sd5; drive_i();
    tick();
    check("rst_rearm_trig", busy, 1'b1);
    wait_done("after_rst", 2000);
    ticks(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
